// File: rtl/jtag_master.sv
// JTAG TAP master: runs DR/IR scans and TAP resets from a single-command interface,
// generating tck from a clk_50_ divider and returning the captured TDO bits.
module jtag_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_50_,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [2:0] {StResetSeq, StIdle, StPre, StShift, StPost, StDone} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] DivDone = 8'(CLK_DIV - 2);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  cnt_q, cnt_d, len_q, len_d;
  logic [31:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic        ir_q, ir_d, err_q, err_d, pwr_q, pwr_d;
  logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, rsp_err_q, rsp_err_d;
  logic        accept, cmd_bad, half_tick, tail;
  logic [5:0]  cnt_inc, pre_len;

  assign cmd_ready = (state_q == StIdle) || (state_q == StDone);
  // The power-up reset sequence ends without a completion pulse.
  assign rsp_valid = (state_q == StDone) && !pwr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    data_d     = data_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ir_d       = ir_q;
    err_d      = err_q;
    pwr_d      = pwr_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;

    accept    = cmd_valid && cmd_ready;
    cmd_bad   = (cmd_op == 2'd3) || ((cmd_op != 2'd2) && ((cmd_len == 6'd0) || (cmd_len > 6'd32)));
    half_tick = (div_q == DivLast);
    cnt_inc   = cnt_q + 6'd1;
    pre_len   = ir_q ? 6'd4 : 6'd3;
    // Final low half-period after the last falling edge of a sequence.
    tail      = !tck_q && (((state_q == StPost) && (cnt_q == 6'd2)) ||
                           ((state_q == StResetSeq) && (cnt_q == 6'd6)));

    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
          pwr_d   = 1'b0;
        end
        if (accept) begin
          ir_d    = (cmd_op == 2'd1);
          len_d   = cmd_len;
          data_d  = cmd_data;
          err_d   = cmd_bad;
          cap_d   = '0;
          div_d   = '0;
          cnt_d   = '0;
          tck_d   = 1'b0;
          tms_d   = !cmd_bad;
          tdi_d   = 1'b0;
          state_d = (cmd_op == 2'd2) ? StResetSeq : StPre;
        end
      end
      default: begin
        if ((state_q == StPre) && err_q) begin
          state_d    = StDone;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else if (tail) begin
          if (div_q >= DivDone) begin
            state_d    = StDone;
            rsp_data_d = cap_q;
            rsp_err_d  = 1'b0;
          end else begin
            div_d = div_q + 8'd1;
          end
        end else if (half_tick) begin
          div_d = '0;
          tck_d = !tck_q;
          if (!tck_q) begin
            cnt_d = cnt_inc;
            if (state_q == StShift) cap_d[cnt_q[4:0]] = tdo;
            if ((state_q == StPre) && (cnt_inc == pre_len)) begin
              state_d = StShift;
              cnt_d   = '0;
            end
            if ((state_q == StShift) && (cnt_inc == len_q)) begin
              state_d = StPost;
              cnt_d   = '0;
            end
          end else begin
            // Falling edge: present tms/tdi for the next rising edge.
            tdi_d = 1'b0;
            case (state_q)
              StResetSeq: tms_d = (cnt_q < 6'd5);
              StPre:      tms_d = ir_q ? (cnt_q < 6'd2) : (cnt_q == 6'd0);
              StShift: begin
                tms_d = (cnt_q == (len_q - 6'd1));
                tdi_d = data_q[cnt_q[4:0]];
              end
              default:    tms_d = (cnt_q == 6'd0);
            endcase
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50_ or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StResetSeq;
      div_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ir_q       <= 1'b0;
      err_q      <= 1'b0;
      pwr_q      <= 1'b1;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ir_q       <= ir_d;
      err_q      <= err_d;
      pwr_q      <= pwr_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
    end
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk_50_ cycles per TCK half-period; legal range 2..255.
REQ-002 SHALL have one clock and an asynchronous active-low reset, as listed in REQ-003 and REQ-004.
REQ-003 SHALL have port clk_50_, input, 1 bit: system clock; all logic in this domain.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the master is idle in Run-Test/Idle and accepts a command.
REQ-007 SHALL have port cmd_op, input, 2 bits: 0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (treated as error).
REQ-008 SHALL have port cmd_len, input, 6 bits: scan length, legal 1..32.
REQ-009 SHALL have port cmd_data, input, 32 bits: shift-in data, LSB shifted first.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_data, output, 32 bits: captured TDO, right-aligned, bit0 = first bit sampled.
REQ-012 SHALL have port rsp_err, output, 1 bit: qualifies rsp_valid; high = command rejected.
REQ-013 SHALL have port tck, output, 1 bit: JTAG clock, idles low.
REQ-014 SHALL have port tms, output, 1 bit: JTAG mode select.
REQ-015 SHALL have port tdi, output, 1 bit: JTAG data to the target.
REQ-016 SHALL have port tdo, input, 1 bit: JTAG data from the target; treated as synchronous to tck.

Function
REQ-017 SHALL accept a command on a clk_50_ edge where cmd_valid && cmd_ready, latching cmd_op, cmd_len and cmd_data; cmd_ready SHALL drop the next cycle.
REQ-018 SHALL generate tck from a divider:
- each half-period lasts CLK_DIV clk_50_ cycles, so the full period is 2*CLK_DIV;
- tck SHALL run only while a sequence is active;
- tck SHALL be low when idle.
REQ-019 SHALL present the first tms/tdi value in the cycle after acceptance; the first tck rise SHALL follow CLK_DIV cycles later.
REQ-020 SHALL change tms/tdi only on tck falling edges, and SHALL register tdo in the clk_50_ cycle in which tck rises.
REQ-021 SHALL drive TMS per rising edge for a DR scan as: 1, 0, 0, then (len-1)×0, then 1, 1, 0 — a total of len+5 edges ending in Run-Test/Idle.
REQ-022 SHALL drive TMS per rising edge for an IR scan as: 1, 1, 0, 0, then (len-1)×0, then 1, 1, 0 — a total of len+6 edges.
REQ-023 SHALL shift on the len Shift-state edges: tdi = cmd_data bit k on the k-th shift edge, and the sampled tdo goes to rsp_data bit k; bits above len-1 SHALL be 0.
REQ-024 SHALL handle the TAP reset command as TMS 1,1,1,1,1,0 (6 edges), with tdi = 0 and rsp_data = 0.
REQ-025 SHALL hold tdi at 0 outside Shift states.
REQ-026 SHALL complete a sequence as follows:
- rsp_valid high for exactly 1 cycle at the end of the final tck low half-period;
- cmd_ready SHALL rise in the same cycle;
- rsp_data and rsp_err SHALL hold until the next rsp_valid.
REQ-027 SHALL reject cmd_len = 0, cmd_len > 32, or cmd_op = 3 (cmd_op 2 ignores cmd_len):
- no tck edges;
- rsp_valid and rsp_err SHALL be high 2 cycles after acceptance;
- rsp_data = 0.
REQ-028 SHALL ignore cmd_valid while cmd_ready is low; there is no rsp backpressure.
REQ-029 SHALL use FSM states RESETSEQ, IDLE, PRE (Select/Capture edges), SHIFT, POST (Exit1/Update/Idle edges) and DONE:
- IDLE→PRE or IDLE→RESETSEQ on acceptance;
- PRE→SHIFT after 3 (DR) or 4 (IR) edges;
- SHIFT→POST after len edges;
- POST→DONE after 2 edges, and RESETSEQ→DONE after 6 edges;
- DONE→IDLE after 1 cycle.
REQ-030 SHALL keep an internal shift count of 6 bits and compare it against the latched length; there is no wrap past 32.

Reset
REQ-031 SHALL, while rstn is low, asynchronously force: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, and the divider and counters to 0.
REQ-032 SHALL, on rstn release, automatically run the TAP reset sequence (REQ-024) and raise cmd_ready at its end, with no rsp_valid pulse.
REQ-033 SHALL, if rstn asserts mid-scan, abandon the scan with no rsp_valid, then apply REQ-031 and REQ-032.

Verification (CLK_DIV=4, bench TAP model on tck/tms/tdi/tdo)
REQ-034 SHALL verify power-up: release rstn → 6 tck rises at an 8-cycle period, TMS 1,1,1,1,1,0 → model in Run-Test/Idle, cmd_ready=1, no rsp_valid.
REQ-035 SHALL verify a DR scan: op=0, len=8, data=0xA5, model DR preloaded 0x3C → TMS 1,0,0,0×7,1,1,0 (13 edges); tdi 1,0,1,0,0,1,0,1; model DR=0xA5; rsp_data=0x0000003C, rsp_err=0.
REQ-036 SHALL verify an IR scan: op=1, len=4, data=0x2, model IR capture 0x1 → 10 edges, TMS 1,1,0,0,0,0,0,1,1,0; model IR=0x2; rsp_data=0x1.
REQ-037 SHALL verify length boundaries:
- len=32, data=0xFFFFFFFF, model returns 0xDEADBEEF → rsp_data=0xDEADBEEF;
- len=0 → zero tck edges, rsp_err=1 two cycles after acceptance;
- len=33 → zero tck edges, rsp_err=1 two cycles after acceptance.
REQ-038 SHALL verify rstn low at the 3rd shift edge of a DR len=16 scan → same cycle tck=0, tms=1; after release, the reset sequence is followed by cmd_ready, and no rsp_valid is ever seen for the aborted scan.
REQ-039 SHALL verify back-to-back commands with cmd_valid held high → the second is accepted in the rsp_valid cycle of the first; a cmd_valid during busy produces no extra accept.
